systolic_tile_sched: RTL
========================

SYSTOLIC_TILE_SCHED -- requirements
Module: systolic_tile_sched

Interface
REQ-001 SHALL have parameter systolic_size, default 8, meaning tile edge in elements.
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of tile index counters.
REQ-003 SHALL have parameters baseaddr_A, baseaddr_B and baseaddr_C, defaults 32'h00000000, 32'h40000000 and 32'h80000000, meaning matrix base addresses.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state is rising-edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port go, input, 1 bit: start request, sampled in IDLE only.
REQ-007 SHALL have port abort, input, 1 bit: cancel the run.
REQ-008 SHALL have port matrix_size, input, 32 bits: N, the square matrix edge in elements.
REQ-009 SHALL have port tile_done, input, 1 bit: one-cycle pulse from the tile engine.
REQ-010 SHALL have port tile_go, output, 1 bit: one-cycle tile start pulse.
REQ-011 SHALL have ports tile_addr_A, tile_addr_B and tile_addr_C, outputs, 32 bits each: element addresses of the current tile.
REQ-012 SHALL have port acc_clear, output, 1 bit: current tile is the first k-step (tk==0).
REQ-013 SHALL have port acc_last, output, 1 bit: current tile is the last k-step, so C is written back.
REQ-014 SHALL have ports busy (1 bit), done (1 bit pulse), err (1 bit, sticky) and tile_count (32 bits), all outputs.

Function
REQ-015 SHALL compute T = ceil(N/systolic_size) in SETUP and latch it with N; matrix_size changes during a run SHALL be ignored.
REQ-016 SHALL iterate ti (outer), then tj, then tk (inner), each over 0..T-1, for T^3 tiles.
REQ-017 SHALL use tile_addr_A = baseaddr_A + ti*S*N + tk*S, where S = systolic_size.
REQ-018 SHALL use tile_addr_B = baseaddr_B + tk*S*N + tj*S.
REQ-019 SHALL use tile_addr_C = baseaddr_C + ti*S*N + tj*S.
REQ-020 SHALL use modulo-2^32 address arithmetic, updated incrementally; no runtime multiply other than the constant S*N.
REQ-021 SHALL implement the FSM states IDLE, SETUP, ISSUE, WAIT, NEXT and FINISH.
REQ-022 IDLE SHALL move to SETUP on go=1.
REQ-023 SETUP SHALL move to FINISH with err set if N==0; otherwise it SHALL move to ISSUE.
REQ-024 ISSUE SHALL assert tile_go for exactly one cycle, then move to WAIT.
REQ-025 WAIT SHALL hold until tile_done=1, then move to NEXT.
REQ-026 NEXT SHALL advance the indices and move to ISSUE, or to FINISH after the last tile.
REQ-027 FINISH SHALL pulse done for one cycle, then return to IDLE.
REQ-028 SHALL have latency: go sampled at edge t gives tile_go high in cycle t+2; tile_done at edge t gives the next tile_go in cycle t+2.
REQ-029 SHALL keep the address, acc_clear and acc_last outputs registered and stable from ISSUE through WAIT.
REQ-030 SHALL ignore tile_done outside WAIT; tile_done arriving in the same cycle as tile_go SHALL be ignored.
REQ-031 SHALL ignore go while busy.
REQ-032 SHALL drive busy=1 in every state except IDLE.
REQ-033 SHALL increment tile_count on each accepted tile_done and clear it on go.
REQ-034 On abort=1 in any non-IDLE state, SHALL return to IDLE on the next edge, with no done pulse and tile_go forced 0; abort SHALL have priority over tile_done.
REQ-035 SHALL clear err on an accepted go; err SHALL otherwise hold.
REQ-036 SHALL handle wrap-around as follows: tk wraps to 0 and increments tj; tj wraps and increments ti; ti==T-1, tj==T-1, tk==T-1 completes the run.

Reset
REQ-037 When reset=0, SHALL asynchronously enter IDLE.
REQ-038 When reset=0, SHALL drive tile_go, busy, done, err, acc_clear and acc_last to 0.
REQ-039 When reset=0, SHALL clear tile_count and all indices to 0 and load the address outputs with their respective base addresses.
REQ-040 Reset mid-run SHALL discard all progress; a new go SHALL be required afterwards.

Structure
REQ-041 SHALL place the FSM state enum and the default base-address constants in a shared package (systolic_pkg).
REQ-042 SHALL place the index counters and incremental address update in one sub-module, systolic_tile_addr_gen; the FSM SHALL stay in the top module.

Verification
REQ-043 Bench SHALL check: S=8, N=16, go -> 8 tile_go pulses; tile 0 at A=base_A, B=base_B, C=base_C with acc_clear=1 and acc_last=0.
REQ-044 Bench SHALL check: same run, tile 1 -> A=base_A+8, B=base_B+128, C=base_C, acc_last=1; tile 2 -> A=base_A, B=base_B+8, C=base_C+8.
REQ-045 Bench SHALL check: same run, completion -> done pulse after the 8th tile_done, tile_count=8, busy low the following cycle.
REQ-046 Bench SHALL check: N=10, S=8 -> T=2 with 8 tiles; N=8 -> exactly 1 tile with acc_clear=acc_last=1.
REQ-047 Bench SHALL check: N=0 -> no tile_go, done pulse exactly 2 cycles after go, err=1; err cleared by the next go.
REQ-048 Bench SHALL check: abort in WAIT of tile 3 -> IDLE next cycle, no done pulse, tile_count=3; stray tile_done in IDLE -> no state change; reset mid-run -> all outputs at reset values immediately.

Source files
------------

// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : systolic_pkg
// Description : Shared types and constants for the systolic tile scheduler.
//               Holds the scheduler FSM state encoding and the default base
//               addresses of the A, B and C matrices.
// Revision    : 1.0 - initial release
// ============================================================================
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ISSUE  = 3'd2,
        WAIT   = 3'd3,
        NEXT   = 3'd4,
        FINISH = 3'd5
    } state_t;

    localparam logic [31:0] c_base_addr_a = 32'h0000_0000;
    localparam logic [31:0] c_base_addr_b = 32'h4000_0000;
    localparam logic [31:0] c_base_addr_c = 32'h8000_0000;

endpackage
`default_nettype wire

// File: rtl/systolic_tile_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : systolic_tile_addr_gen
// Description : Tile index counters (ti outer, tj, tk inner) and incremental
//               A/B/C tile address generation. The only multiply is S*N,
//               taken once at run start; every tile step is add-only.
// Ports       : clk, i_reset (async, active-low)
//               i_init        - start a run: latch T and S*N, zero indices
//               i_step        - advance to the next tile
//               i_matrix_size - N, sampled only on i_init
//               o_addr_a/b/c  - element addresses of the current tile
//               o_acc_clear   - current tile has tk == 0
//               o_acc_last    - current tile has tk == T-1
//               o_last_tile   - current tile is the final one of the run
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_tile_addr_gen
    import systolic_pkg::*;
#(
    parameter int          SYSTOLIC_SIZE = 8,
    parameter int          CNT_W         = 16,
    parameter logic [31:0] BASEADDR_A    = c_base_addr_a,
    parameter logic [31:0] BASEADDR_B    = c_base_addr_b,
    parameter logic [31:0] BASEADDR_C    = c_base_addr_c
) (
    input  logic        clk,
    input  logic        i_reset,
    input  logic        i_init,
    input  logic        i_step,
    input  logic [31:0] i_matrix_size,
    output logic [31:0] o_addr_a,
    output logic [31:0] o_addr_b,
    output logic [31:0] o_addr_c,
    output logic        o_acc_clear,
    output logic        o_acc_last,
    output logic        o_last_tile
);

    localparam logic [31:0] c_s = 32'(SYSTOLIC_SIZE);

    logic [CNT_W-1:0] r_ti, r_tj, r_tk, r_t;
    logic [31:0]      r_sn;                         // S*N, one tile row of elements
    logic [31:0]      r_row_a, r_col_b, r_row_c;    // addresses at tk == 0 / tj == 0
    logic [31:0]      r_addr_a, r_addr_b, r_addr_c;
    logic             r_acc_clear, r_acc_last;

    logic [CNT_W-1:0] w_t, w_t_max;
    logic             w_tk_end, w_tj_end, w_ti_end;

    // ceil(N/S) written as quotient plus remainder test so N near 2^32 cannot overflow
    assign w_t      = CNT_W'(i_matrix_size / c_s + ((i_matrix_size % c_s != 32'd0) ? 32'd1 : 32'd0));
    assign w_t_max  = r_t - CNT_W'(1);
    assign w_tk_end = (r_tk == w_t_max);
    assign w_tj_end = (r_tj == w_t_max);
    assign w_ti_end = (r_ti == w_t_max);

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            r_ti        <= '0;
            r_tj        <= '0;
            r_tk        <= '0;
            r_t         <= '0;
            r_sn        <= '0;
            r_row_a     <= BASEADDR_A;
            r_col_b     <= BASEADDR_B;
            r_row_c     <= BASEADDR_C;
            r_addr_a    <= BASEADDR_A;
            r_addr_b    <= BASEADDR_B;
            r_addr_c    <= BASEADDR_C;
            r_acc_clear <= 1'b0;
            r_acc_last  <= 1'b0;
        end else if (i_init) begin
            r_ti        <= '0;
            r_tj        <= '0;
            r_tk        <= '0;
            r_t         <= w_t;
            r_sn        <= c_s * i_matrix_size;
            r_row_a     <= BASEADDR_A;
            r_col_b     <= BASEADDR_B;
            r_row_c     <= BASEADDR_C;
            r_addr_a    <= BASEADDR_A;
            r_addr_b    <= BASEADDR_B;
            r_addr_c    <= BASEADDR_C;
            r_acc_clear <= 1'b1;
            r_acc_last  <= (w_t == CNT_W'(1));
        end else if (i_step) begin
            if (!w_tk_end) begin
                // walk along the k dimension: A moves right, B moves down
                r_tk        <= r_tk + CNT_W'(1);
                r_addr_a    <= r_addr_a + c_s;
                r_addr_b    <= r_addr_b + r_sn;
                r_acc_clear <= 1'b0;
                r_acc_last  <= ((r_tk + CNT_W'(1)) == w_t_max);
            end else begin
                r_tk        <= '0;
                r_acc_clear <= 1'b1;
                r_acc_last  <= (w_t_max == '0);
                if (!w_tj_end) begin
                    r_tj     <= r_tj + CNT_W'(1);
                    r_col_b  <= r_col_b + c_s;
                    r_addr_a <= r_row_a;
                    r_addr_b <= r_col_b + c_s;
                    r_addr_c <= r_addr_c + c_s;
                end else begin
                    r_tj     <= '0;
                    r_ti     <= r_ti + CNT_W'(1);
                    r_row_a  <= r_row_a + r_sn;
                    r_addr_a <= r_row_a + r_sn;
                    r_col_b  <= BASEADDR_B;
                    r_addr_b <= BASEADDR_B;
                    r_row_c  <= r_row_c + r_sn;
                    r_addr_c <= r_row_c + r_sn;
                end
            end
        end
    end

    assign o_addr_a    = r_addr_a;
    assign o_addr_b    = r_addr_b;
    assign o_addr_c    = r_addr_c;
    assign o_acc_clear = r_acc_clear;
    assign o_acc_last  = r_acc_last;
    assign o_last_tile = w_tk_end && w_tj_end && w_ti_end;

endmodule
`default_nettype wire

// File: rtl/systolic_tile_sched.sv
`default_nettype none
// ============================================================================
// Module      : systolic_tile_sched
// Description : Schedules the T^3 tiles of an NxN matrix multiply onto a
//               systolic tile engine (T = ceil(N/S)), handshaking with
//               tile_go / tile_done and supplying per-tile A/B/C addresses.
// Ports       : clk, reset (async, active-low)
//               go, abort, matrix_size       - run control
//               tile_done                    - engine completion pulse
//               tile_go, tile_addr_A/B/C,
//               acc_clear, acc_last          - per-tile command
//               busy, done, err, tile_count  - status
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_tile_sched
    import systolic_pkg::*;
#(
    parameter int          systolic_size = 8,
    parameter int          CNT_W         = 16,
    parameter logic [31:0] baseaddr_A    = c_base_addr_a,
    parameter logic [31:0] baseaddr_B    = c_base_addr_b,
    parameter logic [31:0] baseaddr_C    = c_base_addr_c
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic        abort,
    input  logic [31:0] matrix_size,
    input  logic        tile_done,
    output logic        tile_go,
    output logic [31:0] tile_addr_A,
    output logic [31:0] tile_addr_B,
    output logic [31:0] tile_addr_C,
    output logic        acc_clear,
    output logic        acc_last,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] tile_count
);

    state_t      r_state, w_state_nxt;
    logic        r_err;
    logic [31:0] r_tile_count;

    logic w_go_acc, w_done_acc, w_init, w_step, w_last_tile, w_zero_n;

    assign w_zero_n = (matrix_size == 32'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_err        <= 1'b0;
            r_tile_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_go_acc)
                r_err <= 1'b0;
            else if (r_state == SETUP && !abort && w_zero_n)
                r_err <= 1'b1;
            if (w_go_acc)
                r_tile_count <= '0;
            else if (w_done_acc)
                r_tile_count <= r_tile_count + 32'd1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_go_acc    = 1'b0;
        w_done_acc  = 1'b0;
        w_init      = 1'b0;
        w_step      = 1'b0;
        if (r_state != IDLE && abort) begin
            // abort outranks everything, including a coincident tile_done
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (go) begin
                        w_go_acc    = 1'b1;
                        w_state_nxt = SETUP;
                    end
                end
                SETUP: begin
                    if (w_zero_n) begin
                        w_state_nxt = FINISH;
                    end else begin
                        w_init      = 1'b1;
                        w_state_nxt = ISSUE;
                    end
                end
                ISSUE:   w_state_nxt = WAIT;
                WAIT: begin
                    if (tile_done) begin
                        w_done_acc  = 1'b1;
                        w_state_nxt = NEXT;
                    end
                end
                NEXT: begin
                    if (w_last_tile) begin
                        w_state_nxt = FINISH;
                    end else begin
                        w_step      = 1'b1;
                        w_state_nxt = ISSUE;
                    end
                end
                FINISH:  w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    systolic_tile_addr_gen #(
        .SYSTOLIC_SIZE (systolic_size),
        .CNT_W         (CNT_W),
        .BASEADDR_A    (baseaddr_A),
        .BASEADDR_B    (baseaddr_B),
        .BASEADDR_C    (baseaddr_C)
    ) u_addr_gen (
        .clk           (clk),
        .i_reset       (reset),
        .i_init        (w_init),
        .i_step        (w_step),
        .i_matrix_size (matrix_size),
        .o_addr_a      (tile_addr_A),
        .o_addr_b      (tile_addr_B),
        .o_addr_c      (tile_addr_C),
        .o_acc_clear   (acc_clear),
        .o_acc_last    (acc_last),
        .o_last_tile   (w_last_tile)
    );

    // an abort seen in ISSUE or FINISH suppresses that cycle's pulse
    assign tile_go    = (r_state == ISSUE) && !abort;
    assign done       = (r_state == FINISH) && !abort;
    assign busy       = (r_state != IDLE);
    assign err        = r_err;
    assign tile_count = r_tile_count;

endmodule
`default_nettype wire
